int_arbiter: RTL and testbench
==============================

Name: int_arbiter

Overview:
- Collects NUM_SRC external interrupt lines and drives a single level request into the core interrupt controller's int_i.
- Synchronises each line and captures it as level- or edge-triggered, masks it, and picks one winner by fixed priority (lowest index wins).
- Sequences request -> taken -> claim -> complete so the core never re-enters on a request that is already being serviced.
- Software accesses it through a small register port on the peripheral bus.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- TIMEOUT_CYC, 1024, service watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- src_i  in  NUM_SRC  asynchronous interrupt lines, active high
- int_taken_i  in  1  pulse from the interrupt controller: the trap was entered (its int_assert_o)
- req_i  in  1  bus request, single-cycle pulse
- we_i  in  1  1 = write, 0 = read
- addr_i  in  8  byte offset, word aligned
- wdata_i  in  32  write data
- rdata_o  out  32  read data, valid while ack_o = 1
- ack_o  out  1  bus acknowledge, one cycle after req_i
- int_o  out  1  level request to the interrupt controller
- int_id_o  out  5  id of the current winner, for debug

Behaviour:
- Reset: every output is 0; all registers are 0; state is S_IDLE.
- Registers:
  - 0x00 PENDING: read-only; a write of 1 to a bit clears that edge-mode pending bit.
  - 0x04 ENABLE: read/write.
  - 0x08 EDGE_CFG: read/write; 1 = edge mode.
  - 0x0C CLAIM: read-only.
  - 0x10 COMPLETE: write-only, reads return 0.
  - 0x14 STATUS: read-only.
  - Unmapped offsets read 0 and ignore writes.
  - Only bits [NUM_SRC-1:0] of each register are implemented; upper bits read 0.
- Bus: ack_o rises exactly 1 cycle after req_i, with rdata_o valid in the same cycle; a back-to-back req_i is accepted every cycle.
- Source capture:
  - Each source passes through a 2-flop synchroniser.
  - Edge mode: pending is set on a synchronised 0->1 transition.
  - Level mode: pending follows the synchronised level.
  - If an edge-pending bit is set and cleared in the same cycle, set wins.
- Eligible set = PENDING & ENABLE. Winner = lowest set index.
- State machine: S_IDLE, S_REQ, S_CLAIM, S_SERVICE.
  - S_IDLE: if any source is eligible, latch the winner id and go to S_REQ. int_o = 1 from the cycle after entry.
  - S_REQ: int_o held at 1.
    - On int_taken_i: go to S_CLAIM and drop int_o to 0.
    - If the latched source stops being eligible before int_taken_i: withdraw to S_IDLE and drop int_o.
    - int_taken_i and withdrawal in the same cycle: int_taken_i wins.
  - S_CLAIM: a CLAIM read returns {27'b0, id} + 1 (0 means none), clears that source's edge-mode pending bit, and moves to S_SERVICE.
  - S_SERVICE: a COMPLETE write whose wdata_i[4:0] equals the latched id + 1 returns to S_IDLE. Mismatched ids are ignored.
  - A CLAIM read in S_IDLE or S_REQ returns 0 and has no side effect.
  - A CLAIM read in S_SERVICE returns the same id again, with no further side effect.
- Latency: if src_i is high at clock edge 0, int_o is high after edge 4 (sync 2, pending 1, state 1).
- While the state is not S_IDLE, a higher-priority arrival does not pre-empt; it is re-arbitrated on return to S_IDLE.
- Reset asserted mid-sequence returns to S_IDLE and clears all pending, enable and in-service state.
- STATUS bits:
  - [1:0] state index.
  - [6:2] latched id.
  - [7] timeout sticky, cleared by writing 1.

Optional Feature:
- Macro INT_ARB_TIMEOUT_EN.
- Defined: a counter runs in S_SERVICE. Reaching TIMEOUT_CYC forces S_IDLE, sets STATUS[7], and clears the counter. The counter also clears on leaving S_SERVICE.
- Undefined: no counter; S_SERVICE waits indefinitely; STATUS[7] reads 0.

Decomposition:
- Shared include alongside the existing CSR defines: register offsets (INT_ARB_PENDING ... INT_ARB_STATUS) and the four state encodings (one-hot, 4 bits).
- One sub-module, int_src_sync: per-source 2-flop synchroniser plus rising-edge detect, instantiated NUM_SRC times via generate.

Test Plan:
- ENABLE=0x05, EDGE_CFG=0, src_i[2] held high at edge 0 -> int_o=1 after edge 4, int_id_o=2; int_taken_i pulse -> int_o=0; CLAIM read=3; COMPLETE write 3 -> S_IDLE, int_o re-asserts because the level is still high.
- Edge mode on sources 0 and 3, both pulse in the same cycle -> winner 0; after its claim and complete, source 3 is requested; CLAIM read=4; PENDING=0 after both.
- Withdraw: level source 1 drops while in S_REQ, no int_taken_i -> int_o=0 next cycle, state S_IDLE, no CLAIM side effect (read=0).
- Wrong COMPLETE: write 7 while servicing id 2 -> stays in S_SERVICE (STATUS[1:0]=3); write 3 -> S_IDLE.
- Reset pulse while in S_SERVICE -> all outputs 0, PENDING/ENABLE=0, STATUS=0.
- With INT_ARB_TIMEOUT_EN, TIMEOUT_CYC=16: claim then no COMPLETE -> after 16 cycles state S_IDLE, STATUS[7]=1; write 0x80 to STATUS -> bit clears.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
// int_arbiter_pkg: register offsets, one-hot state encodings and helpers shared by the interrupt arbiter.
package int_arbiter_pkg;
   localparam logic [7:0] INT_ARB_PENDING  = 8'h00;
   localparam logic [7:0] INT_ARB_ENABLE   = 8'h04;
   localparam logic [7:0] INT_ARB_EDGE_CFG = 8'h08;
   localparam logic [7:0] INT_ARB_CLAIM    = 8'h0C;
   localparam logic [7:0] INT_ARB_COMPLETE = 8'h10;
   localparam logic [7:0] INT_ARB_STATUS   = 8'h14;
   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_REQ     = 4'b0010,
      S_CLAIM   = 4'b0100,
      S_SERVICE = 4'b1000
   } state_e;
   // Software sees the state as a 2-bit index rather than the one-hot code
   function automatic logic [1:0] state_idx(input logic [3:0] s);
      return {s[3] | s[2], s[3] | s[1]};
   endfunction
endpackage

// File: rtl/int_src_sync.sv
// int_src_sync: 2-flop synchroniser for one interrupt line plus rising-edge detect on the synchronised level.
module int_src_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic src_i,
   output logic level_o,
   output logic rise_o
);
   logic [2:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[1:0], src_i};
   always_ff @(posedge clk) sync_q <= !rst_n ? 3'b000 : sync_d;
   assign level_o = sync_q[1];
   assign rise_o  = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/int_arbiter.sv
// int_arbiter: fixed-priority interrupt arbiter with request/taken/claim/complete handshake and register port.
// Optional service watchdog enabled by defining INT_ARB_TIMEOUT_EN.
module int_arbiter
   import int_arbiter_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               int_taken_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [7:0]         addr_i,
   input  logic [31:0]        wdata_i,
   output logic [31:0]        rdata_o,
   output logic               ack_o,
   output logic               int_o,
   output logic [4:0]         int_id_o
);
   logic [NUM_SRC-1:0] lvl, rise, elig;
   logic [NUM_SRC-1:0] pend_q, pend_d, en_q, en_d, edge_q, edge_d;
   logic [31:0]        elig32, clr, rd_val, rdata_q, rdata_d;
   state_e             state_q, state_d;
   logic [4:0]         id_q, id_d, win;
   logic               int_q, int_d, ack_q, ack_d, to_q, to_d;
   logic               wr, rd, claim_rd, complete, unused_w;
`ifdef INT_ARB_TIMEOUT_EN
   logic [31:0]        cnt_q, cnt_d;
`endif

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      int_src_sync u_sync (.clk(clk), .rst_n(rst_n), .src_i(src_i[i]), .level_o(lvl[i]), .rise_o(rise[i]));
   end

   assign wr       = req_i & we_i;
   assign rd       = req_i & ~we_i;
   assign claim_rd = rd && addr_i == INT_ARB_CLAIM;
   assign complete = wr && addr_i == INT_ARB_COMPLETE && wdata_i[4:0] == id_q + 5'd1;
   assign elig     = pend_q & en_q;
   assign elig32   = 32'(elig);
   assign unused_w = ^{wdata_i, clr, elig32, 32'(TIMEOUT_CYC)};

   always_comb begin
      win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (elig[i]) win = 5'(i);
      state_d = state_q;
      id_d    = id_q;
      clr     = (wr && addr_i == INT_ARB_PENDING) ? wdata_i : '0;
      to_d    = to_q & ~(wr && addr_i == INT_ARB_STATUS && wdata_i[7]);
      case (state_q)
         S_IDLE: if (|elig) begin
            state_d = S_REQ;
            id_d    = win;
         end
         // taken beats withdrawal when both happen in the same cycle
         S_REQ: state_d = int_taken_i ? S_CLAIM : elig32[id_q] ? S_REQ : S_IDLE;
         S_CLAIM: if (claim_rd) begin
            state_d  = S_SERVICE;
            clr[id_q] = 1'b1;
         end
         S_SERVICE: if (complete) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef INT_ARB_TIMEOUT_EN
      cnt_d = '0;
      if (state_q == S_SERVICE && state_d == S_SERVICE) begin
         cnt_d = cnt_q + 32'd1;
         if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
            state_d = S_IDLE;
            to_d    = 1'b1;
            cnt_d   = '0;
         end
      end
`else
      to_d = 1'b0;
`endif
      // a fresh edge outranks a clear landing in the same cycle
      pend_d  = (edge_q & (rise | (pend_q & ~clr[NUM_SRC-1:0]))) | (~edge_q & lvl);
      en_d    = (wr && addr_i == INT_ARB_ENABLE) ? wdata_i[NUM_SRC-1:0] : en_q;
      edge_d  = (wr && addr_i == INT_ARB_EDGE_CFG) ? wdata_i[NUM_SRC-1:0] : edge_q;
      int_d   = state_q == S_REQ && state_d == S_REQ;
      rd_val  = addr_i == INT_ARB_PENDING  ? 32'(pend_q) :
                addr_i == INT_ARB_ENABLE   ? 32'(en_q) :
                addr_i == INT_ARB_EDGE_CFG ? 32'(edge_q) :
                addr_i == INT_ARB_CLAIM    ? ((state_q == S_CLAIM || state_q == S_SERVICE) ? 32'(id_q) + 32'd1 : '0) :
                addr_i == INT_ARB_STATUS   ? {24'b0, to_q, id_q, state_idx(state_q)} : '0;
      rdata_d = rd ? rd_val : '0;
      ack_d   = req_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         pend_q  <= '0;
         en_q    <= '0;
         edge_q  <= '0;
         int_q   <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         to_q    <= 1'b0;
`ifdef INT_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         edge_q  <= edge_d;
         int_q   <= int_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         to_q    <= to_d;
`ifdef INT_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign int_o    = int_q;
   assign int_id_o = id_q;
   assign ack_o    = ack_q;
   assign rdata_o  = rdata_q;
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: scoreboard bench for int_arbiter driven by directed and random stimulus against a behavioural model.
module tb_int_arbiter;
   localparam int N = 8;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0] src_i = '0;
   logic int_taken_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
   logic [7:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic ack_o, int_o;
   logic [4:0] int_id_o;
   int vec = 0, err = 0;
   bit chk_en = 1'b0;
   logic [32:0] exp_q[$];
   // behavioural model: synchroniser history, register contents, state 0..3 = IDLE/REQ/CLAIM/SERVICE
   bit [N-1:0] m_s1, m_s2, m_s3, m_pend, m_en, m_edge;
   int m_st = 0, m_id = 0;
   bit m_int = 1'b0;

   always #5 clk = ~clk;

   int_arbiter #(.NUM_SRC(N), .TIMEOUT_CYC(1024)) dut (
      .clk(clk), .rst_n(rst_n), .src_i(src_i), .int_taken_i(int_taken_i),
      .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .ack_o(ack_o), .int_o(int_o), .int_id_o(int_id_o));

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a)
         8'h00: return 32'(m_pend);
         8'h04: return 32'(m_en);
         8'h08: return 32'(m_edge);
         8'h0C: return m_st >= 2 ? 32'(m_id + 1) : 32'd0;
         8'h14: return 32'(m_id * 4 + m_st);
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      bit [N-1:0] rise, clr, elig;
      int nst;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_s3 = '0; m_pend = '0; m_en = '0; m_edge = '0;
         m_st = 0; m_id = 0; m_int = 1'b0;
      end else begin
         if (req_i) exp_q.push_back({!we_i, we_i ? 32'd0 : m_read(addr_i)});
         rise = m_s2 & ~m_s3;
         elig = m_pend & m_en;
         clr = (req_i && we_i && addr_i == 8'h00) ? wdata_i[N-1:0] : '0;
         nst = m_st;
         if (m_st == 0 && elig != 0) begin
            nst = 1;
            m_id = $clog2(int'(elig & (~elig + 1'b1)));
         end else if (m_st == 1) nst = int_taken_i ? 2 : (elig[m_id] ? 1 : 0);
         else if (m_st == 2 && req_i && !we_i && addr_i == 8'h0C) begin
            nst = 3;
            clr[m_id] = 1'b1;
         end else if (m_st == 3 && req_i && we_i && addr_i == 8'h10 && wdata_i[4:0] == 5'(m_id + 1)) nst = 0;
         for (int i = 0; i < N; i++)
            m_pend[i] = m_edge[i] ? (rise[i] || (m_pend[i] && !clr[i])) : m_s2[i];
         if (req_i && we_i && addr_i == 8'h04) m_en = wdata_i[N-1:0];
         if (req_i && we_i && addr_i == 8'h08) m_edge = wdata_i[N-1:0];
         m_int = m_st == 1 && nst == 1;
         m_st = nst;
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = src_i;
      end
   end

   always @(negedge clk) begin : monitor
      logic [32:0] e;
      if (chk_en) begin
         cmp("int_o", 32'(int_o), 32'(m_int));
         cmp("int_id_o", 32'(int_id_o), 32'(m_id));
         if (ack_o || exp_q.size() != 0) begin
            cmp("ack_o", 32'(ack_o), 32'(exp_q.size() != 0));
            if (ack_o && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (e[32]) cmp("rdata_o", rdata_o, e[31:0]);
            end else exp_q.delete();
         end
      end
   end

   task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
      @(negedge clk);
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic wait_int(input bit lvl);
      int n = 0;
      while (int_o !== lvl && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (int_o !== lvl) cmp("wait_int_timeout", 32'(int_o), 32'(lvl));
   endtask

   task automatic take();
      int_taken_i = 1'b1;
      @(negedge clk);
      int_taken_i = 1'b0;
   endtask

   task automatic serve(input int id);
      wait_int(1'b1);
      cmp("winner", 32'(int_id_o), 32'(id));
      take();
      cmp("int_drop", 32'(int_o), 32'd0);
      bus(1'b0, 8'h0C, 0);
      bus(1'b1, 8'h10, 32'(id + 1));
   endtask

   initial begin
      logic [7:0] addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40};
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      // level source 2, four-edge latency, wrong then right COMPLETE
      bus(1'b1, 8'h04, 32'h05);
      bus(1'b1, 8'h08, 32'h00);
      src_i = 8'h04;
      repeat (4) @(negedge clk);
      cmp("lat_before", 32'(int_o), 32'd0);
      @(negedge clk);
      cmp("lat_int", 32'(int_o), 32'd1);
      cmp("lat_id", 32'(int_id_o), 32'd2);
      take();
      cmp("taken_drop", 32'(int_o), 32'd0);
      bus(1'b0, 8'h0C, 0);
      bus(1'b1, 8'h10, 32'd7);
      bus(1'b0, 8'h14, 0);
      bus(1'b1, 8'h10, 32'd3);
      repeat (2) @(negedge clk);
      cmp("reassert", 32'(int_o), 32'd1);
      take();
      bus(1'b0, 8'h0C, 0);
      src_i = '0;
      bus(1'b1, 8'h10, 32'd3);
      repeat (8) @(negedge clk);
      // simultaneous edges on sources 0 and 3
      bus(1'b1, 8'h08, 32'h09);
      bus(1'b1, 8'h04, 32'h09);
      src_i = 8'h09;
      @(negedge clk);
      src_i = '0;
      serve(0);
      serve(3);
      repeat (2) @(negedge clk);
      bus(1'b0, 8'h00, 0);
      // withdrawal of level source 1
      bus(1'b1, 8'h08, 32'h00);
      bus(1'b1, 8'h04, 32'h02);
      src_i = 8'h02;
      wait_int(1'b1);
      src_i = '0;
      wait_int(1'b0);
      bus(1'b0, 8'h0C, 0);
      bus(1'b0, 8'h14, 0);
      // reset while in service
      bus(1'b1, 8'h04, 32'h01);
      src_i = 8'h01;
      wait_int(1'b1);
      take();
      bus(1'b0, 8'h0C, 0);
      src_i = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cmp("rst_int", 32'(int_o), 32'd0);
      bus(1'b0, 8'h00, 0);
      bus(1'b0, 8'h04, 0);
      bus(1'b0, 8'h14, 0);
      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n = $urandom_range(0, 499) != 0;
         src_i = src_i ^ (N'($urandom) & N'($urandom) & N'($urandom));
         int_taken_i = $urandom_range(0, 7) == 0;
         req_i = $urandom_range(0, 2) == 0;
         we_i = $urandom_range(0, 1) == 1;
         addr_i = addrs[$urandom_range(0, 7)];
         wdata_i = (addr_i == 8'h10 && $urandom_range(0, 1) == 1) ? 32'(m_id + 1) : $urandom;
         @(negedge clk);
      end
      rst_n = 1'b1; req_i = 1'b0; we_i = 1'b0; int_taken_i = 1'b0;
      repeat (3) @(negedge clk);
      cmp("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
